calc_seq_alu: RTL and testbench

Parametrised, clocked successor to the 4-bit switch calculator. It registers two W-bit two's-complement operands on a START pulse and executes add, subtract, reverse subtract or absolute value in one cycle, or a signed multiply in W+1 cycles. It returns the result with per-operation and sticky overflow flags, and can chain operations through an accumulator. It sits between the KEY/SW input conditioning and the HEX display decoders.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_shift_add_mul.sv | 54 +++++
 rtl/calc_seq_alu.sv | 184 ++++++++++++++++++
 tb/tb_calc_seq_alu.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator: operation codes and FSM states.
package calc_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_ABSB  = 3'b010;
    localparam logic [2:0] OP_ABSB2 = 3'b011;
    localparam logic [2:0] OP_RADD  = 3'b100;
    localparam logic [2:0] OP_RSUB  = 3'b101;
    localparam logic [2:0] OP_ABSA  = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/calc_shift_add_mul.sv
// Iterative unsigned W x W shift-add multiplier; one partial product per step.
module calc_shift_add_mul #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [W-1:0]     mcand,
    input  logic [W-1:0]     mplier,
    output logic [2*W-1:0]   product,
    output logic             last
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] prod_q, prod_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W:0]     sum;

    // Multiplier sits in the low half and is consumed LSB-first as the product shifts right.
    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        if (load) begin
            prod_d  = {{W{1'b0}}, mplier};
            mcand_d = mcand;
            cnt_d   = CW'(W - 1);
        end else if (step) begin
            prod_d = {sum, prod_q[W-1:1]};
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product = prod_q;
    assign last    = (cnt_q == '0);

endmodule

// File: rtl/calc_seq_alu.sv
// Clocked signed calculator: single-cycle add/sub/abs, iterative multiply, accumulator chaining.
//  state  | meaning
//  IDLE   | waiting for START, operands latched on START
//  EXEC   | single-cycle op: write R/OVF, pulse DONE
//  MUL    | one shift-add iteration per cycle
//  FIX    | apply product sign, write R/OVF, pulse DONE
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    input  logic         START,
    input  logic [2:0]   OP,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         ACC,
    input  logic         CLR_OVF,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] R,
    output logic         OVF,
    output logic         OVF_STICKY
);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
    logic [2:0]     op_q, op_d;
    logic           neg_q, neg_d;
    logic           ovf_q, ovf_d, sticky_q, sticky_d;
    logic           done_q, done_d, busy_q, busy_d;

    logic [W-1:0]   a_sel, mag_a, mag_b;
    logic           mul_load, mul_step, mul_last;
    logic [2*W-1:0] product, sprod;
    logic [W:0]     sprod_hi;
    logic           mul_ovf;
    logic [W-1:0]   add_s, sub_ab, sub_ba, abs_a, abs_b, ex_res;
    logic           ex_ovf;

    calc_shift_add_mul #(.W(W)) u_mul (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .load    (mul_load),
        .step    (mul_step),
        .mcand   (mag_a),
        .mplier  (mag_b),
        .product (product),
        .last    (mul_last)
    );

    always_comb begin
        a_sel = ACC ? r_q : A;
        mag_a = a_sel[W-1] ? ('0 - a_sel) : a_sel;
        mag_b = B[W-1] ? ('0 - B) : B;

        sprod    = neg_q ? ('0 - product) : product;
        sprod_hi = sprod[2*W-1:W-1];
        // Fits in W bits only if the top W+1 bits are a pure sign extension.
        mul_ovf  = (sprod_hi != '0) && (sprod_hi != '1);

        add_s  = a_q + b_q;
        sub_ab = a_q - b_q;
        sub_ba = b_q - a_q;
        abs_a  = a_q[W-1] ? ('0 - a_q) : a_q;
        abs_b  = b_q[W-1] ? ('0 - b_q) : b_q;

        ex_res = '0;
        ex_ovf = 1'b0;
        case (op_q)
            OP_ADD, OP_RADD: begin
                ex_res = add_s;
                ex_ovf = (a_q[W-1] == b_q[W-1]) && (add_s[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                ex_res = sub_ab;
                ex_ovf = (a_q[W-1] != b_q[W-1]) && (sub_ab[W-1] != a_q[W-1]);
            end
            OP_RSUB: begin
                ex_res = sub_ba;
                ex_ovf = (b_q[W-1] != a_q[W-1]) && (sub_ba[W-1] != b_q[W-1]);
            end
            OP_ABSB, OP_ABSB2: begin
                ex_res = abs_b;
                ex_ovf = (b_q == MIN_VAL);
            end
            OP_ABSA: begin
                ex_res = abs_a;
                ex_ovf = (a_q == MIN_VAL);
            end
            default: begin
                ex_res = '0;
                ex_ovf = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        r_d      = r_q;
        ovf_d    = ovf_q;
        sticky_d = CLR_OVF ? 1'b0 : sticky_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    a_d   = a_sel;
                    b_d   = B;
                    op_d  = OP;
                    neg_d = a_sel[W-1] ^ B[W-1];
                    if (OP == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        state_d  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                r_d     = ex_res;
                ovf_d   = ex_ovf;
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (ex_ovf) sticky_d = 1'b1;
            end
            S_MUL: begin
                mul_step = 1'b1;
                if (mul_last) state_d = S_FIX;
            end
            S_FIX: begin
                r_d     = sprod[W-1:0];
                ovf_d   = mul_ovf;
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (mul_ovf) sticky_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            r_q      <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            r_q      <= r_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign R          = r_q;
    assign OVF        = ovf_q;
    assign OVF_STICKY = sticky_q;

endmodule

// File: tb/tb_calc_seq_alu.sv
// Directed and randomized bench for calc_seq_alu against an integer-arithmetic reference model.
module tb_calc_seq_alu;
    localparam int W = 4;
    localparam int VMAX = (1 << (W-1)) - 1;
    localparam int VMIN = -(1 << (W-1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         acc, clr_ovf;
    logic         busy, done, ovf, ovf_sticky;
    logic [W-1:0] r;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] r_model;
    bit           sticky_model;

    calc_seq_alu #(.W(W)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .START      (start),
        .OP         (op),
        .A          (a),
        .B          (b),
        .ACC        (acc),
        .CLR_OVF    (clr_ovf),
        .BUSY       (busy),
        .DONE       (done),
        .R          (r),
        .OVF        (ovf),
        .OVF_STICKY (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Exact mathematical result; wrap and overflow are derived from it afterwards.
    function automatic int ref_full(input logic [2:0] o, input int x, input int y);
        case (o)
            3'b000, 3'b100: return x + y;
            3'b001:         return x - y;
            3'b101:         return y - x;
            3'b010, 3'b011: return iabs(y);
            3'b110:         return iabs(x);
            default:        return x * y;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},   busy,       0);
        chk({tag, "_done"},   done,       0);
        chk({tag, "_r"},      r,          0);
        chk({tag, "_ovf"},    ovf,        0);
        chk({tag, "_sticky"}, ovf_sticky, 0);
    endtask

    task automatic run_op(input logic [2:0] o, input int x, input int y,
                          input bit use_acc, input bit poke, input bit clr);
        int aval, full, n, busy_n, lat;
        logic [W-1:0] er;
        bit eovf;
        aval = use_acc ? sx(r_model) : x;
        full = ref_full(o, aval, y);
        er   = full[W-1:0];
        eovf = (full < VMIN) || (full > VMAX);
        lat  = (o == 3'b111) ? W + 1 : 1;

        @(negedge clk);
        start = 1'b1; op = o; a = x[W-1:0]; b = y[W-1:0]; acc = use_acc; clr_ovf = clr;
        @(negedge clk);
        start = 1'b0; acc = 1'b0;
        a = W'($urandom()); b = W'($urandom());
        n = 0; busy_n = 0;
        while (!done && n < 4*W + 8) begin
            busy_n += int'(busy);
            if (poke && n == 2) begin
                start = 1'b1; op = 3'b000; a = 1; b = 1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        sticky_model = (clr ? 1'b0 : sticky_model) | eovf;
        r_model = er;
        chk("latency",   n,          lat);
        chk("busy_cyc",  busy_n,     lat);
        chk("done",      done,       1);
        chk("r",         r,          er);
        chk("ovf",       ovf,        eovf);
        chk("sticky",    ovf_sticky, sticky_model);
        chk("busy_fall", busy,       0);
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_after", busy, 0);
        chk("r_hold",     r,    er);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; acc = 1'b0; clr_ovf = 1'b0;
        r_model = '0; sticky_model = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_op(3'b000, 4, 3, 0, 0, 0);
        run_op(3'b001, 5, -4, 0, 0, 0);
        run_op(3'b101, -7, -7, 0, 0, 0);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        sticky_model = 1'b0;
        chk("clr_sticky", ovf_sticky, 0);

        run_op(3'b110, -8, 0, 0, 0, 0);
        run_op(3'b010, 0, -3, 0, 0, 0);
        run_op(3'b011, 0, 0, 0, 0, 0);
        run_op(3'b010, 0, -8, 0, 0, 1);

        run_op(3'b111, -3, 2, 0, 1, 0);
        run_op(3'b111, 7, 3, 0, 0, 0);
        run_op(3'b111, -8, -1, 0, 0, 0);
        run_op(3'b111, -8, -8, 0, 0, 0);
        run_op(3'b111, -8, 1, 0, 0, 0);

        run_op(3'b000, 2, 1, 0, 0, 0);
        run_op(3'b000, 0, 2, 1, 0, 0);
        run_op(3'b111, 0, 2, 1, 0, 0);

        // Abort a multiply partway through with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; op = 3'b111; a = 4'd3; b = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort");
        r_model = '0; sticky_model = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (8) begin
                @(negedge clk);
                seen += int'(done) + int'(busy);
            end
            chk("no_done_after_abort", seen, 0);
        end
        run_op(3'b000, 1, 1, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro;
            int rx, ry;
            ro = 3'($urandom_range(0, 7));
            rx = int'($urandom_range(0, (1 << W) - 1)) + VMIN;
            ry = int'($urandom_range(0, (1 << W) - 1)) + VMIN;
            run_op(ro, rx, ry, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
